// File: rtl/flappy_game_ctrl.sv
// Frame-rate sequencer for the flappy bird game: bird physics, pipe scroll,
// score and the IDLE/PLAY/DYING/OVER flow, all advanced once per frame_tick.
//
//   state | meaning
//   IDLE  | bird parked at start row, waiting for a flap to begin
//   PLAY  | physics, scroll and scoring run on every frame_tick
//   DYING | gravity-only fall for DEATH_FRAMES ticks, scroll frozen
//   OVER  | everything frozen until a flap returns to IDLE
module flappy_game_ctrl #(
    parameter int BIRD_Y0      = 240,
    parameter int GROUND_Y     = 440,
    parameter int GRAVITY      = 1,
    parameter int FLAP_VEL     = -8,
    parameter int VMAX         = 8,
    parameter int SCROLL_STEP  = 2,
    parameter int PIPE_PERIOD  = 160,
    parameter int DEATH_FRAMES = 60
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        frame_tick,
    input  logic        flap,
    input  logic        collision,
    output logic [1:0]  state,
    output logic [9:0]  bird_y,
    output logic [9:0]  scroll_x,
    output logic [15:0] score,
    output logic        score_pulse,
    output logic        game_over
);
    localparam int DW = $clog2(DEATH_FRAMES);

    localparam logic signed [6:0]  GRAV7    = 7'(GRAVITY);
    localparam logic signed [6:0]  VMAX7    = 7'(VMAX);
    localparam logic signed [5:0]  FLAP6    = 6'(FLAP_VEL);
    localparam logic signed [10:0] GROUND11 = 11'(GROUND_Y);
    localparam logic [9:0]         GROUND10 = 10'(GROUND_Y);
    localparam logic [9:0]         BIRD_Y10 = 10'(BIRD_Y0);
    localparam logic [10:0]        STEP11   = 11'(SCROLL_STEP);
    localparam logic [10:0]        PERIOD11 = 11'(PIPE_PERIOD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               flap_q;
    logic               flap_pend_q, flap_pend_d;
    logic               coll_lat_q, coll_lat_d;
    logic signed [5:0]  vel_q, vel_d;
    logic [9:0]         bird_y_q, bird_y_d;
    logic [9:0]         scroll_q, scroll_d;
    logic [15:0]        score_q, score_d;
    logic               pulse_q, pulse_d;
    logic               gover_q;
    logic [DW-1:0]      death_cnt_q, death_cnt_d;

    logic               flap_edge;
    logic signed [6:0]  vel_inc;
    logic signed [5:0]  vel_grav;
    logic signed [5:0]  vel_n;
    logic signed [10:0] y_sum;
    logic [9:0]         y_clamp;
    logic [10:0]        scroll_sum;

    assign flap_edge = flap & ~flap_q;

    // A flap edge coinciding with the tick counts for that tick.
    assign vel_inc  = {vel_q[5], vel_q} + GRAV7;
    assign vel_grav = (vel_inc > VMAX7) ? VMAX7[5:0] : vel_inc[5:0];
    assign vel_n    = ((state_q == PLAY) && (flap_pend_q || flap_edge)) ? FLAP6 : vel_grav;

    assign y_sum = $signed({1'b0, bird_y_q}) + {{5{vel_n[5]}}, vel_n};
    always_comb begin
        if (y_sum < 11'sd0)
            y_clamp = 10'd0;
        else if (y_sum > GROUND11)
            y_clamp = GROUND10;
        else
            y_clamp = y_sum[9:0];
    end

    assign scroll_sum = {1'b0, scroll_q} + STEP11;

    always_comb begin
        state_d     = state_q;
        flap_pend_d = flap_pend_q;
        vel_d       = vel_q;
        bird_y_d    = bird_y_q;
        scroll_d    = scroll_q;
        score_d     = score_q;
        pulse_d     = 1'b0;
        death_cnt_d = death_cnt_q;

        if (frame_tick)
            coll_lat_d = 1'b0;
        else if (state_q == PLAY && collision)
            coll_lat_d = 1'b1;
        else
            coll_lat_d = coll_lat_q;

        case (state_q)
            IDLE: begin
                bird_y_d = BIRD_Y10;
                vel_d    = 6'sd0;
                scroll_d = 10'd0;
                if (flap_edge) begin
                    state_d     = PLAY;
                    score_d     = 16'd0;
                    flap_pend_d = 1'b1;
                end
            end
            PLAY: begin
                if (flap_edge)
                    flap_pend_d = 1'b1;
                if (frame_tick) begin
                    flap_pend_d = 1'b0;
                    vel_d       = vel_n;
                    bird_y_d    = y_clamp;
                    if (coll_lat_q || collision || y_clamp == GROUND10) begin
                        state_d     = DYING;
                        death_cnt_d = DW'(DEATH_FRAMES - 1);
                    end else if (scroll_sum >= PERIOD11) begin
                        scroll_d = 10'(scroll_sum - PERIOD11);
                        if (score_q != 16'hFFFF) begin
                            score_d = score_q + 16'd1;
                            pulse_d = 1'b1;
                        end
                    end else begin
                        scroll_d = scroll_sum[9:0];
                    end
                end
            end
            DYING: begin
                flap_pend_d = 1'b0;
                if (frame_tick) begin
                    vel_d    = vel_n;
                    bird_y_d = y_clamp;
                    if (death_cnt_q == '0)
                        state_d = OVER;
                    else
                        death_cnt_d = death_cnt_q - 1'b1;
                end
            end
            OVER: begin
                if (flap_edge) begin
                    state_d  = IDLE;
                    bird_y_d = BIRD_Y10;
                    vel_d    = 6'sd0;
                    scroll_d = 10'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // flap_q resets high so a button held through reset yields no edge.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            flap_q      <= 1'b1;
            flap_pend_q <= 1'b0;
            coll_lat_q  <= 1'b0;
            vel_q       <= 6'sd0;
            bird_y_q    <= BIRD_Y10;
            scroll_q    <= 10'd0;
            score_q     <= 16'd0;
            pulse_q     <= 1'b0;
            gover_q     <= 1'b0;
            death_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flap_q      <= flap;
            flap_pend_q <= flap_pend_d;
            coll_lat_q  <= coll_lat_d;
            vel_q       <= vel_d;
            bird_y_q    <= bird_y_d;
            scroll_q    <= scroll_d;
            score_q     <= score_d;
            pulse_q     <= pulse_d;
            gover_q     <= (state_d == OVER);
            death_cnt_q <= death_cnt_d;
        end
    end

    assign state       = state_q;
    assign bird_y      = bird_y_q;
    assign scroll_x    = scroll_q;
    assign score       = score_q;
    assign score_pulse = pulse_q;
    assign game_over   = gover_q;
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: a vector table for game start plus
// hand-written sequences for falling, scoring, collision, dying and reset.
module tb_flappy_game_ctrl;
    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic        frame_tick;
    logic        flap;
    logic        collision;
    logic [1:0]  state;
    logic [9:0]  bird_y;
    logic [9:0]  scroll_x;
    logic [15:0] score;
    logic        score_pulse;
    logic        game_over;

    int nchecks = 0;
    int nerr    = 0;

    int m_vel, m_y, m_scroll, m_score, m_pulse;

    typedef struct {
        logic t;
        logic f;
        logic c;
        int   st;
        int   y;
        int   sx;
        int   sc;
        int   pl;
        int   go;
    } vec_t;

    vec_t vecs[7];

    flappy_game_ctrl dut (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .frame_tick  (frame_tick),
        .flap        (flap),
        .collision   (collision),
        .state       (state),
        .bird_y      (bird_y),
        .scroll_x    (scroll_x),
        .score       (score),
        .score_pulse (score_pulse),
        .game_over   (game_over)
    );

    always #20 vga_clk = ~vga_clk;

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic f, input logic c);
        @(negedge vga_clk);
        frame_tick = t;
        flap       = f;
        collision  = c;
        @(posedge vga_clk);
        #1;
    endtask

    // Expected effect of one tick in PLAY/DYING; returns 1 when the bird lands.
    function automatic int model_tick(input int flapped, input int playing, input int coll);
        int landed;
        m_pulse = 0;
        m_vel   = flapped ? -8 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
        m_y     = m_y + m_vel;
        if (m_y < 0)   m_y = 0;
        if (m_y > 440) m_y = 440;
        landed = (m_y == 440) ? 1 : 0;
        if (playing != 0 && landed == 0 && coll == 0) begin
            m_scroll = m_scroll + 2;
            if (m_scroll >= 160) begin
                m_scroll = m_scroll - 160;
                m_score  = m_score + 1;
                m_pulse  = 1;
            end
        end
        return landed;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int landed;
        int ticks;
        int f;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 0, 240, 0, 0, 0, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1, 240, 0, 0, 0, 0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1, 232, 2, 0, 0, 0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1, 225, 4, 0, 0, 0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1, 219, 6, 0, 0, 0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1, 219, 6, 0, 0, 0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1, 214, 8, 0, 0, 0};

        sys_rst_n  = 1'b0;
        frame_tick = 1'b0;
        flap       = 1'b0;
        collision  = 1'b0;
        #50;
        chk("reset_state", int'(state), 0);
        chk("reset_bird_y", int'(bird_y), 240);
        chk("reset_scroll", int'(scroll_x), 0);
        chk("reset_score", int'(score), 0);
        chk("reset_pulse", int'(score_pulse), 0);
        chk("reset_gover", int'(game_over), 0);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cyc(vecs[i].t, vecs[i].f, vecs[i].c);
            chk($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
            chk($sformatf("vec%0d_bird_y", i), int'(bird_y), vecs[i].y);
            chk($sformatf("vec%0d_scroll", i), int'(scroll_x), vecs[i].sx);
            chk($sformatf("vec%0d_score", i), int'(score), vecs[i].sc);
            chk($sformatf("vec%0d_pulse", i), int'(score_pulse), vecs[i].pl);
            chk($sformatf("vec%0d_gover", i), int'(game_over), vecs[i].go);
        end

        // Free fall from vel=-5 until the ground is reached.
        m_vel = -5; m_y = 214; m_scroll = 8; m_score = 0;
        landed = 0;
        ticks  = 0;
        while (landed == 0 && ticks < 200) begin
            cyc(1'b1, 1'b0, 1'b0);
            landed = model_tick(0, 1, 0);
            ticks++;
            chk($sformatf("fall%0d_bird_y", ticks), int'(bird_y), m_y);
            chk($sformatf("fall%0d_scroll", ticks), int'(scroll_x), m_scroll);
            chk($sformatf("fall%0d_state", ticks), int'(state), landed ? 2 : 1);
        end
        chk("fall_landed", landed, 1);

        // Flap and collision during DYING must be ignored.
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("dying_flap_ignored", int'(state), 2);
        for (int i = 0; i < 59; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("dying_59_state", int'(state), 2);
        chk("dying_59_gover", int'(game_over), 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("dying_60_state", int'(state), 3);
        chk("dying_60_gover", int'(game_over), 1);
        chk("over_bird_y", int'(bird_y), 440);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("over_hold_state", int'(state), 3);
        chk("over_hold_bird_y", int'(bird_y), 440);
        chk("over_hold_scroll", int'(scroll_x), m_scroll);
        cyc(1'b0, 1'b1, 1'b0);
        chk("over_exit_state", int'(state), 0);
        chk("over_exit_bird_y", int'(bird_y), 240);
        chk("over_exit_scroll", int'(scroll_x), 0);
        chk("over_exit_gover", int'(game_over), 0);
        chk("over_exit_score", int'(score), m_score);
        cyc(1'b0, 1'b0, 1'b0);

        // Long play with flaps on the tick itself, through one scroll wrap.
        cyc(1'b0, 1'b1, 1'b0);
        chk("play2_start_state", int'(state), 1);
        chk("play2_start_score", int'(score), 0);
        cyc(1'b0, 1'b0, 1'b0);
        m_vel = 0; m_y = 240; m_scroll = 0; m_score = 0;
        for (int i = 0; i < 85; i++) begin
            f = (i > 0 && m_y >= 300) ? 1 : 0;
            cyc(1'b1, f[0], 1'b0);
            landed = model_tick((i == 0 || f != 0) ? 1 : 0, 1, 0);
            chk($sformatf("play%0d_bird_y", i), int'(bird_y), m_y);
            chk($sformatf("play%0d_scroll", i), int'(scroll_x), m_scroll);
            chk($sformatf("play%0d_score", i), int'(score), m_score);
            chk($sformatf("play%0d_pulse", i), int'(score_pulse), m_pulse);
            chk($sformatf("play%0d_state", i), int'(state), 1);
            cyc(1'b0, 1'b0, 1'b0);
            if (m_pulse != 0) chk($sformatf("play%0d_pulse_end", i), int'(score_pulse), 0);
        end
        chk("play2_score_one", int'(score), 1);

        // One-cycle collision between ticks kills the bird on the next tick.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        landed = model_tick(0, 1, 1);
        chk("coll_state", int'(state), 2);
        chk("coll_scroll", int'(scroll_x), m_scroll);
        chk("coll_score", int'(score), m_score);
        chk("coll_bird_y", int'(bird_y), m_y);
        for (int i = 0; i < 59; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            landed = model_tick(0, 0, 0);
        end
        chk("coll_59_state", int'(state), 2);
        chk("coll_59_bird_y", int'(bird_y), m_y);
        cyc(1'b1, 1'b0, 1'b0);
        chk("coll_60_state", int'(state), 3);
        chk("coll_60_gover", int'(game_over), 1);
        chk("coll_60_scroll", int'(scroll_x), m_scroll);

        // Asynchronous reset between edges, then flap held through release.
        @(negedge vga_clk);
        flap = 1'b1;
        #5;
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_score", int'(score), 0);
        chk("async_rst_bird_y", int'(bird_y), 240);
        chk("async_rst_gover", int'(game_over), 0);
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        chk("held_flap_state", int'(state), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("released_state", int'(state), 0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("press_state", int'(state), 1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
